// File: rtl/int_div_unit.sv
// int_div_unit: iterative non-restoring integer divider covering RV M-extension
// DIV, DIVU, REM and REMU. One quotient bit per cycle, with a one-cycle fast path
// for divide-by-zero and signed overflow. Valid/ready on issue and result sides.
module int_div_unit #(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 5
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [XLEN-1:0]      dividend,
   input  logic [XLEN-1:0]      divisor,
   input  logic [TAG_WIDTH-1:0] tag_in,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      result,
   output logic [TAG_WIDTH-1:0] tag_out,
   output logic                 div_by_zero
);

   localparam int               CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIVIDE  = 2'd1,
      CORRECT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic                  out_valid_nxt;

   // Operation context captured at accept; the inputs are ignored after that.
   logic signed [XLEN:0]  acc;
   logic [XLEN-1:0]       quo;
   logic [XLEN-1:0]       dvsr;
   logic                  op_rem;
   logic                  neg_quo;
   logic                  neg_rem;
   logic [TAG_WIDTH-1:0]  tag_r;

   logic                  accept;
   logic                  retire;
   logic                  op_signed;
   logic                  zero_div;
   logic                  ovf;
   logic                  fast;
   logic [XLEN-1:0]       fast_res;

   logic signed [XLEN:0]  dv_ext;
   logic signed [XLEN:0]  acc_sh;
   logic signed [XLEN:0]  acc_step;
   logic [XLEN-1:0]       quo_step;
   logic [XLEN-1:0]       rem_mag;
   logic [XLEN-1:0]       quo_fix;
   logic [XLEN-1:0]       rem_fix;
   logic [XLEN-1:0]       corr_res;

   // Two's-complement negation at operand width.
   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
      return '0 - v;
   endfunction

   // Absolute value for signed ops; unsigned ops pass through untouched.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic            is_signed);
      return (is_signed && v[XLEN-1]) ? negate(v) : v;
   endfunction

   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && in_ready && !flush;
   assign retire    = out_valid && out_ready;
   assign op_signed = !op[0];
   assign zero_div  = (divisor == '0);
   assign ovf       = op_signed && (dividend == INT_MIN) && (&divisor);
   assign fast      = zero_div || ovf;

   // Special-case results that bypass the iterative datapath.
   always_comb begin
      fast_res = dividend;
      if (zero_div) begin
         fast_res = op[1] ? dividend : '1;
      end else begin
         fast_res = op[1] ? '0 : dividend;
      end
   end

   // One non-restoring step: shift {acc, quo} left, then add or subtract the
   // divisor depending on the sign of the remainder before the shift. The shift
   // may wrap the top bit, but the post-add/subtract value always fits.
   assign dv_ext   = signed'({1'b0, dvsr});
   assign acc_sh   = {acc[XLEN-1:0], quo[XLEN-1]};
   assign acc_step = acc[XLEN] ? (acc_sh + dv_ext) : (acc_sh - dv_ext);
   assign quo_step = {quo[XLEN-2:0], ~acc_step[XLEN]};

   // Final correction: restore a negative remainder, then apply result signs.
   assign rem_mag  = acc[XLEN] ? (acc[XLEN-1:0] + dvsr) : acc[XLEN-1:0];
   assign quo_fix  = neg_quo ? negate(quo) : quo;
   assign rem_fix  = neg_rem ? negate(rem_mag) : rem_mag;
   assign corr_res = op_rem ? rem_fix : quo_fix;

   // Next-state and registered-output decode; flush overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = fast ? DONE : DIVIDE;
         DIVIDE:  if (cnt == CNT_LAST) state_nxt = CORRECT;
         CORRECT: state_nxt = DONE;
         DONE:    if (retire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
      out_valid_nxt = (state == DONE) && (state_nxt == DONE);
   end

   // Control state: FSM, iteration counter and out_valid.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= out_valid_nxt;
         if (accept) begin
            cnt <= '0;
         end else if (state == DIVIDE) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Result registers: loaded on a fast-path accept or at the correction cycle,
   // then held untouched through DONE.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         result      <= '0;
         tag_out     <= '0;
         div_by_zero <= 1'b0;
      end else if (accept && fast) begin
         result      <= fast_res;
         tag_out     <= tag_in;
         div_by_zero <= zero_div;
      end else if (state == CORRECT) begin
         result      <= corr_res;
         tag_out     <= tag_r;
         div_by_zero <= 1'b0;
      end
   end

   // Iterative datapath: operand magnitudes and sign flags captured at accept,
   // remainder/quotient pair advanced once per DIVIDE cycle.
   always_ff @(posedge CLK) begin
      if (accept) begin
         acc     <= '0;
         quo     <= magnitude(dividend, op_signed);
         dvsr    <= magnitude(divisor, op_signed);
         op_rem  <= op[1];
         neg_quo <= op_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
         neg_rem <= op_signed && dividend[XLEN-1];
         tag_r   <= tag_in;
      end else if (state == DIVIDE) begin
         acc <= acc_step;
         quo <= quo_step;
      end
   end

endmodule

// File: tb/tb_int_div_unit.sv
// tb_int_div_unit: scoreboard bench for int_div_unit at XLEN=32 and XLEN=64.
module tb_int_div_unit;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst_n;
   logic        rst64_n;

   logic        in_valid, in_ready, flush, out_valid, out_ready, div_by_zero;
   logic [1:0]  op;
   logic [31:0] dividend, divisor, result;
   logic [4:0]  tag_in, tag_out;

   logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready, w_div_by_zero;
   logic [1:0]  w_op;
   logic [63:0] w_dividend, w_divisor, w_result;
   logic [4:0]  w_tag_in, w_tag_out;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   int_div_unit #(.XLEN(32), .TAG_WIDTH(5)) dut32 (
      .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .dividend(dividend), .divisor(divisor), .tag_in(tag_in), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .tag_out(tag_out), .div_by_zero(div_by_zero));

   int_div_unit #(.XLEN(64), .TAG_WIDTH(5)) dut64 (
      .CLK(CLK), .rst_n(rst64_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
      .dividend(w_dividend), .divisor(w_divisor), .tag_in(w_tag_in), .flush(w_flush),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
      .tag_out(w_tag_out), .div_by_zero(w_div_by_zero));

   // Reference RISC-V divide semantics built on the simulator's own operators.
   function automatic logic [31:0] model32(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, db;
      sa = a;
      db = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
      case (o)
         2'b00:   return 32'(sa / db);
         2'b01:   return a / b;
         2'b10:   return 32'(sa % db);
         default: return a % b;
      endcase
   endfunction

   task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic [31:0] exp_res, input bit push);
      exp_t e;
      int   g = 0;
      bit   special;
      while (in_ready !== 1'b1 && g < 100) begin
         @(posedge CLK); #1; g++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++; n_err++;
         $display("FAIL issue_wait: in_ready=%b required 1", in_ready);
      end
      op = o; dividend = a; divisor = b; tag_in = t; in_valid = 1'b1;
      special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      if (push) begin
         e.res = {32'd0, exp_res};
         e.tag = t;
         e.dbz = (b == 32'd0);
         e.lat = special ? 1 : 34;
         sb.push_back(e);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait32(output int lat, output logic [31:0] r, output logic [4:0] t,
                         output logic d, output bit ok);
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 200) begin
         @(posedge CLK); #1; lat++;
         if (out_valid === 1'b1) ok = 1'b1;
      end
      r = result; t = tag_out; d = div_by_zero;
   endtask

   task automatic retire32;
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
   endtask

   task automatic issue64(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] t);
      int g = 0;
      while (w_in_ready !== 1'b1 && g < 100) begin
         @(posedge CLK); #1; g++;
      end
      w_op = o; w_dividend = a; w_divisor = b; w_tag_in = t; w_in_valid = 1'b1;
      @(posedge CLK); #1;
      w_in_valid = 1'b0;
   endtask

   task automatic test_reset;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
          tag_out !== 5'd0 || div_by_zero !== 1'b0) begin
         n_err++;
         $display("FAIL reset32: in_ready=%b out_valid=%b result=%h tag=%0d dbz=%b required 1 0 0 0 0",
                  in_ready, out_valid, result, tag_out, div_by_zero);
      end
      n_cmp++;
      if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_result !== 64'd0) begin
         n_err++;
         $display("FAIL reset64: in_ready=%b out_valid=%b result=%h required 1 0 0",
                  w_in_ready, w_out_valid, w_result);
      end
   endtask

   task automatic test_divu_latency;
      logic [1:0]  ops [2] = '{2'b01, 2'b11};
      logic [31:0] exps[2] = '{32'd14, 32'd2};
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic d; bit ok;
      for (int i = 0; i < 2; i++) begin
         issue32(ops[i], 32'd100, 32'd7, 5'd3, exps[i], 1'b1);
         wait32(lat, r, t, d, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || r !== e.res[31:0] || t !== e.tag || d !== e.dbz) begin
            n_err++;
            $display("FAIL unsigned_%0d: result=%h tag=%0d dbz=%b required %h tag %0d dbz %b",
                     i, r, t, d, e.res[31:0], e.tag, e.dbz);
         end
         n_cmp++;
         if (lat != e.lat) begin
            n_err++;
            $display("FAIL unsigned_latency_%0d: edges=%0d required %0d", i, lat, e.lat);
         end
         retire32();
      end
   endtask

   task automatic test_signed;
      logic [1:0]  ops [3] = '{2'b00, 2'b10, 2'b10};
      logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
      logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
      logic [31:0] exps[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic d; bit ok;
      for (int i = 0; i < 3; i++) begin
         issue32(ops[i], as[i], bs[i], 5'(10 + i), exps[i], 1'b1);
         wait32(lat, r, t, d, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || r !== e.res[31:0] || t !== e.tag || d !== e.dbz || lat != e.lat) begin
            n_err++;
            $display("FAIL signed_%0d: result=%h tag=%0d dbz=%b edges=%0d required %h tag %0d dbz %b edges %0d",
                     i, r, t, d, lat, e.res[31:0], e.tag, e.dbz, e.lat);
         end
         retire32();
      end
   endtask

   task automatic test_fast_path;
      logic [1:0]  ops [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
      logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'h8000_0000};
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic d; bit ok;
      for (int i = 0; i < 4; i++) begin
         issue32(ops[i], as[i], bs[i], 5'(20 + i), exps[i], 1'b1);
         wait32(lat, r, t, d, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || r !== e.res[31:0] || t !== e.tag || d !== e.dbz || lat != e.lat) begin
            n_err++;
            $display("FAIL fast_%0d: result=%h tag=%0d dbz=%b edges=%0d required %h tag %0d dbz %b edges %0d",
                     i, r, t, d, lat, e.res[31:0], e.tag, e.dbz, e.lat);
         end
         retire32();
      end
   endtask

   task automatic test_backpressure;
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic d; bit ok; bit stable;
      issue32(2'b01, 32'd1000, 32'd10, 5'd7, 32'd100, 1'b1);
      wait32(lat, r, t, d, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || r !== e.res[31:0] || t !== e.tag) begin
         n_err++;
         $display("FAIL bp_first: result=%h tag=%0d required %h tag %0d", r, t, e.res[31:0], e.tag);
      end
      // A second op is offered while the first result is stalled.
      op = 2'b01; dividend = 32'd50; divisor = 32'd5; tag_in = 5'd9; in_valid = 1'b1;
      stable = 1'b1;
      repeat (10) begin
         @(posedge CLK); #1;
         if (out_valid !== 1'b1 || result !== r || tag_out !== t || in_ready !== 1'b0) stable = 1'b0;
      end
      n_cmp++;
      if (!stable) begin
         n_err++;
         $display("FAIL bp_hold: out_valid=%b result=%h tag=%0d in_ready=%b required 1 %h %0d 0",
                  out_valid, result, tag_out, in_ready, r, t);
      end
      retire32();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_retire: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      e.res = 64'd10; e.tag = 5'd9; e.dbz = 1'b0; e.lat = 34;
      sb.push_back(e);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      wait32(lat, r, t, d, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || r !== e.res[31:0] || t !== e.tag || lat != e.lat) begin
         n_err++;
         $display("FAIL bp_second: result=%h tag=%0d edges=%0d required %h tag %0d edges %0d",
                  r, t, lat, e.res[31:0], e.tag, e.lat);
      end
      retire32();
   endtask

   task automatic test_flush;
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic d; bit ok; bit seen;
      issue32(2'b01, 32'hFFFF_FF00, 32'd3, 5'd11, 32'd0, 1'b0);
      repeat (12) begin @(posedge CLK); #1; end
      flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_divide: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      seen = 1'b0;
      repeat (40) begin @(posedge CLK); #1; if (out_valid !== 1'b0) seen = 1'b1; end
      n_cmp++;
      if (seen) begin
         n_err++;
         $display("FAIL flush_no_result: out_valid=1 required 0");
      end
      // Flush together with a fast-path request must block the accept.
      op = 2'b01; dividend = 32'd5; divisor = 32'd0; tag_in = 5'd1;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(posedge CLK); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_blocks_accept: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      issue32(2'b01, 32'd9, 32'd3, 5'd4, 32'd3, 1'b1);
      wait32(lat, r, t, d, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || r !== e.res[31:0] || t !== e.tag || lat != e.lat) begin
         n_err++;
         $display("FAIL flush_fresh: result=%h tag=%0d edges=%0d required %h tag %0d edges %0d",
                  r, t, lat, e.res[31:0], e.tag, e.lat);
      end
      retire32();
   endtask

   task automatic test_isolation;
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic d; bit ok;
      issue32(2'b01, 32'd100, 32'd7, 5'd21, 32'd14, 1'b1);
      op = 2'b10; dividend = 32'hFFFF_FFFF; divisor = 32'd1; tag_in = 5'd2; in_valid = 1'b1;
      repeat (5) begin @(posedge CLK); #1; end
      in_valid = 1'b0;
      wait32(lat, r, t, d, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || r !== e.res[31:0] || t !== e.tag || (lat + 5) != e.lat) begin
         n_err++;
         $display("FAIL isolation: result=%h tag=%0d edges=%0d required %h tag %0d edges %0d",
                  r, t, lat + 5, e.res[31:0], e.tag, e.lat);
      end
      retire32();
   endtask

   task automatic test_random;
      exp_t e; int lat; logic [31:0] r; logic [4:0] t; logic d; bit ok;
      logic [1:0] o; logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
         if (i == 5) b = 32'd0;
         if (i == 7) a = 32'h8000_0000;
         issue32(o, a, b, 5'(i), model32(o, a, b), 1'b1);
         wait32(lat, r, t, d, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || r !== e.res[31:0] || t !== e.tag || d !== e.dbz || lat != e.lat) begin
            n_err++;
            $display("FAIL random_%0d op=%0d %h/%h: result=%h dbz=%b edges=%0d required %h dbz %b edges %0d",
                     i, o, a, b, r, d, lat, e.res[31:0], e.dbz, e.lat);
         end
         retire32();
      end
   endtask

   task automatic test_xlen64;
      exp_t e; int lat; bit ok; bit seen;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            e.res = 64'h2AAA_AAAA_AAAA_AAAA; e.tag = 5'd5;
            issue64(2'b01, 64'h8000_0000_0000_0000, 64'd3, 5'd5);
         end else begin
            e.res = 64'hFFFF_FFFF_FFFF_FFF2; e.tag = 5'd8;
            issue64(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd8);
         end
         e.dbz = 1'b0; e.lat = 66;
         sb.push_back(e);
         lat = 0; ok = 1'b0;
         while (!ok && lat < 200) begin
            @(posedge CLK); #1; lat++;
            if (w_out_valid === 1'b1) ok = 1'b1;
         end
         e = sb.pop_front();
         n_cmp++;
         if (!ok || w_result !== e.res || w_tag_out !== e.tag || w_div_by_zero !== e.dbz ||
             lat != e.lat) begin
            n_err++;
            $display("FAIL xlen64_%0d: result=%h tag=%0d edges=%0d required %h tag %0d edges %0d",
                     i, w_result, w_tag_out, lat, e.res, e.tag, e.lat);
         end
         w_out_ready = 1'b1;
         @(posedge CLK); #1;
         w_out_ready = 1'b0;
         if (i == 0) begin
            // Reset pulse in the middle of a divide.
            issue64(2'b01, 64'd12345, 64'd7, 5'd6);
            repeat (20) begin @(posedge CLK); #1; end
            rst64_n = 1'b0;
            #1;
            n_cmp++;
            if (w_out_valid !== 1'b0 || w_result !== 64'd0 || w_tag_out !== 5'd0) begin
               n_err++;
               $display("FAIL xlen64_reset_async: out_valid=%b result=%h tag=%0d required 0 0 0",
                        w_out_valid, w_result, w_tag_out);
            end
            #2 rst64_n = 1'b1;
            @(posedge CLK); #1;
            n_cmp++;
            if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
               n_err++;
               $display("FAIL xlen64_reset_release: in_ready=%b out_valid=%b required 1 0",
                        w_in_ready, w_out_valid);
            end
            seen = 1'b0;
            repeat (80) begin @(posedge CLK); #1; if (w_out_valid !== 1'b0) seen = 1'b1; end
            n_cmp++;
            if (seen) begin
               n_err++;
               $display("FAIL xlen64_lost_result: out_valid=1 required 0");
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; rst64_n = 1'b0;
      in_valid = 1'b0; op = 2'b00; dividend = '0; divisor = '0; tag_in = '0;
      flush = 1'b0; out_ready = 1'b0;
      w_in_valid = 1'b0; w_op = 2'b00; w_dividend = '0; w_divisor = '0; w_tag_in = '0;
      w_flush = 1'b0; w_out_ready = 1'b0;
      #12;
      rst_n = 1'b1; rst64_n = 1'b1;
      @(posedge CLK); #1;
      test_reset();
      test_divu_latency();
      test_signed();
      test_fast_path();
      test_backpressure();
      test_flush();
      test_isolation();
      test_random();
      test_xlen64();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: entries=%0d required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
